shift_ram_sweep: RTL

Parametrised RAM-backed sample history for the correlator front end. Each accepted sample is written into a circular buffer of depth 2**AW. The block then sweeps the newest LAGS samples out on dshift, newest first, with valid/first/last framing, so a downstream multiply-accumulate can form one lag per cycle. It adds a working RAM clear, overrun detection and lag indexing, and uses a registered-read RAM.

---
 rtl/shift_ram_pkg.sv | 14 +
 rtl/sdp_ram_reg.sv | 27 ++
 rtl/shift_ram_sweep.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/shift_ram_pkg.sv
// Shared state encodings and sizing helper for the RAM-backed sample history.
package shift_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sdp_ram_reg.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module sdp_ram_reg
  import shift_ram_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  // Zero initial contents so never-written slots read back as 0.
  (* ramstyle = "M9K" *) logic [DW-1:0] mem [depth(AW)] = '{default: '0};

  // Read-before-write on an address collision; the sweep never writes while reading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/shift_ram_sweep.sv
// Circular sample history: writes each accepted sample, then sweeps the newest
// LAGS samples out newest-first with valid/first/last framing and a lag index.
module shift_ram_sweep
  import shift_ram_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 9,
  parameter int LAGS = depth(AW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          sin,
  output logic          busy,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] dshift,
  output logic [AW-1:0] lag,
  output logic          dvalid,
  output logic          dfirst,
  output logic          dlast,
  output logic          ovf
);

  localparam logic [AW-1:0] LAST_K = AW'(LAGS - 1);
  localparam logic [AW-1:0] LAST_A = AW'(depth(AW) - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW-1:0] k_reg, k_next;
  logic [AW-1:0] caddr_reg, caddr_next;
  logic [DW-1:0] dout_reg, dout_next;
  logic          ovf_reg, ovf_next;

  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] q;

  logic          iss_valid, iss_first, iss_last;
  logic          dvalid_reg, dfirst_reg, dlast_reg;
  logic [AW-1:0] lag_reg;

  sdp_ram_reg #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .q    (q)
  );

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    k_next     = k_reg;
    caddr_next = caddr_reg;
    dout_next  = dout_reg;
    ovf_next   = ovf_reg;
    we         = 1'b0;
    waddr      = wptr_reg;
    wdata      = din;
    raddr      = wptr_reg - k_reg;
    iss_valid  = 1'b0;
    iss_first  = 1'b0;
    iss_last   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // clr takes priority; a coincident sample is dropped without flagging ovf.
        if (clr) begin
          caddr_next = '0;
          state_next = ST_CLEAR;
        end else if (sin) begin
          we         = 1'b1;
          dout_next  = din;
          k_next     = '0;
          state_next = ST_SWEEP;
        end
      end

      ST_SWEEP: begin
        iss_valid = 1'b1;
        iss_first = (k_reg == '0);
        if (sin) begin
          ovf_next = 1'b1;
        end
        // An aborted sweep keeps wptr and never marks its last tap.
        if (clr) begin
          caddr_next = '0;
          state_next = ST_CLEAR;
        end else if (k_reg == LAST_K) begin
          iss_last   = 1'b1;
          wptr_next  = wptr_reg + 1'b1;
          state_next = ST_IDLE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end

      ST_CLEAR: begin
        we    = 1'b1;
        waddr = caddr_reg;
        wdata = '0;
        if (sin) begin
          ovf_next = 1'b1;
        end
        if (caddr_reg == LAST_A) begin
          wptr_next  = '0;
          ovf_next   = 1'b0;
          state_next = ST_IDLE;
        end else begin
          caddr_next = caddr_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      wptr_reg   <= '0;
      k_reg      <= '0;
      caddr_reg  <= '0;
      dout_reg   <= '0;
      ovf_reg    <= 1'b0;
      dvalid_reg <= 1'b0;
      dfirst_reg <= 1'b0;
      dlast_reg  <= 1'b0;
      lag_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      wptr_reg   <= wptr_next;
      k_reg      <= k_next;
      caddr_reg  <= caddr_next;
      dout_reg   <= dout_next;
      ovf_reg    <= ovf_next;
      // Issue-cycle flags delayed one cycle to line up with the registered RAM output.
      dvalid_reg <= iss_valid;
      dfirst_reg <= iss_first;
      dlast_reg  <= iss_last;
      lag_reg    <= iss_valid ? k_reg : '0;
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign dout   = dout_reg;
  assign dshift = dvalid_reg ? q : '0;
  assign lag    = lag_reg;
  assign dvalid = dvalid_reg;
  assign dfirst = dfirst_reg;
  assign dlast  = dlast_reg;
  assign ovf    = ovf_reg;

endmodule
